hazard_mdu_ctrl: RTL and testbench

Central pipeline controller for the 5-stage MIPS core.
- Computes stall from Tuse/Tnew comparison of D-stage sources against the E and M destinations.
- Sequences the multiply/divide unit's busy window with a cycle counter.
- Turns an M-stage exception or eret into flush controls.
- Drives the enable and clear inputs of the F/D, D/E and E/M pipeline registers.

---
 rtl/hazard_mdu_ctrl.sv | 101 ++++++++++
 tb/tb_hazard_mdu_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/hazard_mdu_ctrl.sv
// hazard_mdu_ctrl: stall, flush and multiply/divide busy control for a 5-stage MIPS pipeline
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   D_rs/D_rt, D_Tuse_rs/D_Tuse_rt D-stage sources and their Tuse (2'b11 = unused)
//   D_is_md                       D-stage instruction touches the MDU / HI / LO
//   E_A3/E_RFWr/E_Tnew            E-stage destination, write enable, Tnew
//   M_A3/M_RFWr/M_Tnew            M-stage destination, write enable, Tnew
//   E_md_start/E_md_div           MDU issue in E, divide (1) or multiply (0)
//   M_exc/M_eret                  exception or eret at M (flush)
//   stall, F_en, D_en             D-stage stall, PC and F/D enables
//   D_clr, E_clr, M_clr           pipeline register clears
//   md_busy, md_cnt               MDU busy flag and remaining busy cycles
// Optional feature, macro STALL_PERF_EN: adds stall_cycles and flush_count counters.
module hazard_mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic [1:0]       D_Tuse_rs,
  input  logic [1:0]       D_Tuse_rt,
  input  logic             D_is_md,
  input  logic [4:0]       E_A3,
  input  logic             E_RFWr,
  input  logic [1:0]       E_Tnew,
  input  logic [4:0]       M_A3,
  input  logic             M_RFWr,
  input  logic [1:0]       M_Tnew,
  input  logic             E_md_start,
  input  logic             E_md_div,
  input  logic             M_exc,
  input  logic             M_eret,
  output logic             stall,
  output logic             F_en,
  output logic             D_en,
  output logic             D_clr,
  output logic             E_clr,
  output logic             M_clr,
  output logic             md_busy,
`ifdef STALL_PERF_EN
  output logic [31:0]      stall_cycles,
  output logic [15:0]      flush_count,
`endif
  output logic [CNT_W-1:0] md_cnt
);
  typedef enum logic {IDLE, BUSY} md_state_e;
  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic             flush, stall_rs, stall_rt, stall_md, stall_raw;
  always_comb begin
    flush     = M_exc | M_eret;
    // Tuse of 3 can never be exceeded by a 2-bit Tnew, so unused sources drop out naturally
    stall_rs  = (D_rs != 5'd0) && ((E_RFWr && E_A3 == D_rs && E_Tnew > D_Tuse_rs) ||
                                   (M_RFWr && M_A3 == D_rs && M_Tnew > D_Tuse_rs));
    stall_rt  = (D_rt != 5'd0) && ((E_RFWr && E_A3 == D_rt && E_Tnew > D_Tuse_rt) ||
                                   (M_RFWr && M_A3 == D_rt && M_Tnew > D_Tuse_rt));
    stall_md  = D_is_md && (state_q == BUSY || E_md_start);
    stall_raw = (stall_rs | stall_rt | stall_md) & ~flush;
    // reset forces a free-running pipeline with no clears
    stall     = ~reset & stall_raw;
    F_en      = ~stall;
    D_en      = ~stall;
    E_clr     = ~reset & (stall_raw | flush);
    D_clr     = ~reset & flush;
    M_clr     = ~reset & flush;
    // a start killed by flush does not load; an in-flight count keeps running through flush
    md_cnt_d  = (E_md_start && !flush) ? (E_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES)) :
                (state_q == BUSY) ? md_cnt_q - 1'b1 : md_cnt_q;
    state_d   = (md_cnt_d != '0) ? BUSY : IDLE;
    md_busy   = state_q == BUSY;
    md_cnt    = md_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end
`ifdef STALL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] flush_count_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_q + {31'd0, stall};
      flush_count_q  <= flush_count_q + {15'd0, flush};
    end
  end
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif
endmodule

// File: tb/tb_hazard_mdu_ctrl.sv
// tb_hazard_mdu_ctrl: directed plus randomized checks of hazard_mdu_ctrl against a behavioural model
module tb_hazard_mdu_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_rs, D_rt, E_A3, M_A3;
  logic [1:0] D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic       D_is_md, E_RFWr, M_RFWr, E_md_start, E_md_div, M_exc, M_eret;
  logic       stall, F_en, D_en, D_clr, E_clr, M_clr, md_busy;
  logic [3:0] md_cnt;
`ifdef STALL_PERF_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  int          m_stalls, m_flushes;
`endif
  int checks = 0, failures = 0, step = 0;
  int m_rem = 0;
  always #5 clk = ~clk;
  hazard_mdu_ctrl dut (
    .clk(clk), .reset(reset), .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .D_is_md(D_is_md), .E_A3(E_A3), .E_RFWr(E_RFWr), .E_Tnew(E_Tnew), .M_A3(M_A3), .M_RFWr(M_RFWr),
    .M_Tnew(M_Tnew), .E_md_start(E_md_start), .E_md_div(E_md_div), .M_exc(M_exc), .M_eret(M_eret),
    .stall(stall), .F_en(F_en), .D_en(D_en), .D_clr(D_clr), .E_clr(E_clr), .M_clr(M_clr),
    .md_busy(md_busy),
`ifdef STALL_PERF_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
    .md_cnt(md_cnt)
  );
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL step%0d %s got=%0h exp=%0h", step, tag, obs, exp);
    end
  endtask
  function automatic bit needs_wait(logic [4:0] s, logic [1:0] tuse);
    int t = int'(tuse);
    if (s == 0 || t == 3) return 0;
    return (E_RFWr && E_A3 == s && int'(E_Tnew) > t) || (M_RFWr && M_A3 == s && int'(M_Tnew) > t);
  endfunction
  task automatic idle_inputs();
    reset = 0; D_rs = 0; D_rt = 0; D_Tuse_rs = 3; D_Tuse_rt = 3; D_is_md = 0;
    E_A3 = 0; E_RFWr = 0; E_Tnew = 0; M_A3 = 0; M_RFWr = 0; M_Tnew = 0;
    E_md_start = 0; E_md_div = 0; M_exc = 0; M_eret = 0;
  endtask
  // inputs are set just after a falling edge; check settles 1 time unit later, then waits a cycle
  task automatic cyc();
    bit fl, st;
    #1;
    step++;
    fl = M_exc | M_eret;
    st = !reset && !fl && (needs_wait(D_rs, D_Tuse_rs) || needs_wait(D_rt, D_Tuse_rt) ||
                           (D_is_md && (m_rem > 0 || E_md_start)));
    chk("stall", 32'(stall), 32'(st));
    chk("F_en", 32'(F_en), 32'(!st));
    chk("D_en", 32'(D_en), 32'(!st));
    chk("E_clr", 32'(E_clr), 32'(!reset && (st || fl)));
    chk("D_clr", 32'(D_clr), 32'(!reset && fl));
    chk("M_clr", 32'(M_clr), 32'(!reset && fl));
    chk("md_cnt", 32'(md_cnt), 32'(m_rem));
    chk("md_busy", 32'(md_busy), 32'(m_rem != 0));
`ifdef STALL_PERF_EN
    chk("stall_cycles", stall_cycles, 32'(m_stalls));
    chk("flush_count", 32'(flush_count), 32'(m_flushes & 16'hffff));
    if (reset) begin m_stalls = 0; m_flushes = 0; end
    else begin m_stalls += int'(st); m_flushes += int'(fl); end
`endif
    if (reset) m_rem = 0;
    else if (E_md_start && !fl) m_rem = E_md_div ? 10 : 5;
    else if (m_rem > 0) m_rem--;
    @(negedge clk);
  endtask
  initial begin
    logic [4:0] regs [3] = '{5'd0, 5'd8, 5'd9};
    @(negedge clk);
    idle_inputs(); reset = 1;
    cyc(); cyc();
    idle_inputs();
    cyc();
    E_RFWr = 1; E_A3 = 8; E_Tnew = 2; D_rs = 8; D_Tuse_rs = 1;
    cyc();
    D_Tuse_rs = 2;
    cyc();
    D_rs = 0; D_Tuse_rs = 1;
    cyc();
    idle_inputs(); D_is_md = 1; E_md_start = 1; E_md_div = 1;
    cyc();
    E_md_start = 0;
    repeat (11) cyc();
    idle_inputs(); E_RFWr = 1; E_A3 = 8; E_Tnew = 2; D_rs = 8; D_Tuse_rs = 0; M_exc = 1;
    cyc();
    idle_inputs(); E_md_start = 1; M_eret = 1;
    cyc();
    M_eret = 0;
    cyc();
    E_md_start = 0;
    repeat (6) cyc();
    E_md_start = 1; E_md_div = 1;
    cyc();
    E_md_start = 0;
    repeat (4) cyc();
    reset = 1;
    cyc();
    reset = 0;
    repeat (2) cyc();
    repeat (400) begin
      reset = ($urandom_range(49) == 0);
      D_rs = regs[$urandom_range(2)]; D_rt = regs[$urandom_range(2)];
      D_Tuse_rs = 2'($urandom); D_Tuse_rt = 2'($urandom); D_is_md = 1'($urandom);
      E_A3 = regs[$urandom_range(2)]; E_RFWr = 1'($urandom); E_Tnew = 2'($urandom);
      M_A3 = regs[$urandom_range(2)]; M_RFWr = 1'($urandom); M_Tnew = 2'($urandom);
      E_md_start = ($urandom_range(7) == 0); E_md_div = 1'($urandom);
      M_exc = ($urandom_range(9) == 0); M_eret = ($urandom_range(11) == 0);
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
